pll_rst_seq: RTL and testbench
==============================

# pll_rst_seq

PLL control sequencer sitting directly upstream of the PLLE2_ADV feature test in the clk100 domain. It drives the PLL RST, PWRDWN and CLKINSEL pins and watches LOCKED. It enforces a minimum reset pulse, a lock timeout with bounded retries, a post-lock settle window, and clean input switching. Its o_ready output replaces the raw `RST || !LOCKED` term used to hold the downstream counters in reset.

## Interface
- RST_CYCLES, 16: PLL RST pulse width in clk100 cycles, ≥2
- LOCK_TIMEOUT, 4096: cycles allowed in WAIT_LOCK per attempt
- MAX_RETRY, 3: reset retries after the first timeout before FAIL
- SETTLE_CYCLES, 64: consecutive locked cycles required before RUN
- clk100  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- i_locked  in  1  PLL LOCKED, asynchronous to clk100
- i_sel_req  in  1  requested CLKINSEL, level (1 = CLKIN1)
- i_pwrdwn_req  in  1  power-down request, level
- o_pll_rst  out  1  PLL RST
- o_pll_pwrdwn  out  1  PLL PWRDWN
- o_clkinsel  out  1  PLL CLKINSEL
- o_ready  out  1  PLL clocks usable
- o_fail  out  1  sticky lock failure
- o_retries  out  2  timeouts in the current attempt series, saturating

## Operation
- i_locked passes through a 2-flop synchronizer to give locked_s.
- States: RESET, WAIT_LOCK, SETTLE, RUN, PWRDN, FAIL. The state register resets to RESET.
- All outputs are registered Moore decodes of state:
  - o_pll_rst = 1 in RESET, PWRDN and FAIL.
  - o_pll_pwrdwn = 1 only in PWRDN.
  - o_ready = 1 only in RUN.
  - o_fail = 1 only in FAIL.
- Reset values: o_pll_rst=1, o_pll_pwrdwn=0, o_clkinsel=1, o_ready=0, o_fail=0, o_retries=0, counter=0.
- RESET: o_clkinsel loads i_sel_req on entry. o_clkinsel never changes outside RESET. After RST_CYCLES cycles, go to WAIT_LOCK.
- WAIT_LOCK:
  - locked_s=1 → SETTLE.
  - On counter == LOCK_TIMEOUT−1 with locked_s=0: if o_retries == MAX_RETRY → FAIL; else increment o_retries and go to RESET.
- SETTLE: locked_s=0 → RESET, o_retries unchanged. After SETTLE_CYCLES consecutive locked cycles → RUN and clear o_retries.
- RUN exits, in priority order:
  1. i_pwrdwn_req → PWRDN
  2. locked_s=0 → RESET (lock loss)
  3. i_sel_req ≠ o_clkinsel → RESET (input switch)
- PWRDN: stay while i_pwrdwn_req=1. On deassert → RESET and clear o_retries.
- i_pwrdwn_req preempts every state except FAIL.
- FAIL: terminal. Left only by rst.
- A single shared counter of width clog2(max(RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES)) clears on every state change.
- Reset mid-operation: on rst assert, all state and outputs return to reset values immediately.

## Timing
- Edge 0 is the first clk100 edge after rst deasserts. o_pll_rst falls at edge RST_CYCLES.
- locked rise at edge t:
  - locked_s high at t+2
  - SETTLE at t+3
  - o_ready high at t+3+SETTLE_CYCLES
- locked fall in RUN: o_ready low and o_pll_rst high at the edge 3 cycles after the fall.
- i_sel_req change in RUN: o_ready low 1 edge later. o_clkinsel updates on that same edge, with o_pll_rst already high.
- i_pwrdwn_req in any non-FAIL state: o_pll_pwrdwn high 1 edge later.

## Configuration
- PLL_RST_SEQ_AUTOSEL_EN
  - Defined: each lock timeout that leads to a retry also toggles o_clkinsel on entry to RESET (input failover). The RUN switch rule still compares against i_sel_req.
  - Undefined: o_clkinsel only ever follows i_sel_req.

## Structure
- Package pll_rst_seq_pkg holds:
  - state enum (one-hot encoding)
  - default parameter constants
  - retry-counter width constant
- Sub-module pll_lock_sync: generic 2-flop synchronizer with reset value 0, reused for i_locked.

## Test plan
Bench parameters: RST_CYCLES=16, LOCK_TIMEOUT=256, MAX_RETRY=3, SETTLE_CYCLES=8.
- Nominal: rst released, i_locked rises at edge 40 → o_pll_rst falls at edge 16, o_ready=1 at edge 51, o_retries=0.
- Never locks: i_locked=0 → o_retries steps 1, 2, 3; o_fail=1 at edge 1088; o_pll_rst stays 1; i_locked rising afterwards has no effect.
- Lock loss: in RUN, drop i_locked for 20 cycles → o_ready=0 at fall+3, o_pll_rst high for 16 cycles; RUN is re-reached after relock and o_retries stays 0.
- Input switch: in RUN with o_clkinsel=1, set i_sel_req=0 → o_ready=0 and o_clkinsel=0 on the next edge, o_pll_rst=1 for 16 cycles, then relock.
- Power-down: assert i_pwrdwn_req during WAIT_LOCK after one timeout (o_retries=1) → o_pll_pwrdwn=1 and o_pll_rst=1 next edge; on release, o_retries=0 and the 16-cycle RESET restarts.
- With the macro defined: first timeout → o_clkinsel toggles 1→0 on entry to RESET; a lock on CLKIN2 then reaches RUN.

Source files
------------

// File: rtl/pll_rst_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pll_rst_seq_pkg
// Description : Shared types and constants for the PLL reset sequencer:
//               one-hot state enum, default parameter values and the
//               retry-counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package pll_rst_seq_pkg;

  localparam int c_rst_cycles_dflt    = 16;
  localparam int c_lock_timeout_dflt  = 4096;
  localparam int c_max_retry_dflt     = 3;
  localparam int c_settle_cycles_dflt = 64;

  // o_retries is a 2-bit saturating count
  localparam int c_retry_w = 2;

  typedef enum logic [5:0] {
    ST_RESET     = 6'b000001,
    ST_WAIT_LOCK = 6'b000010,
    ST_SETTLE    = 6'b000100,
    ST_RUN       = 6'b001000,
    ST_PWRDN     = 6'b010000,
    ST_FAIL      = 6'b100000
  } pll_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pll_lock_sync.sv
`default_nettype none
// ============================================================================
// Module      : pll_lock_sync
// Description : Generic 2-flop synchronizer, asynchronous active-high reset
//               to 0.
// Ports       : clk  - destination clock
//               rst  - asynchronous active-high reset
//               i_d  - asynchronous input
//               o_q  - synchronized output (2 cycles latency)
// Revision    : 1.0 - initial release
// ============================================================================
module pll_lock_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= '0;
      o_q    <= '0;
    end else begin
      r_meta <= i_d;
      o_q    <= r_meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pll_rst_seq.sv
`default_nettype none
// ============================================================================
// Module      : pll_rst_seq
// Description : PLL control sequencer (clk100 domain). Drives PLL RST, PWRDWN
//               and CLKINSEL, watches LOCKED. Enforces a minimum reset pulse,
//               a lock timeout with bounded retries, a post-lock settle window
//               and clean input switching. o_ready marks PLL clocks usable.
// Ports       : clk100       - system clock
//               rst          - asynchronous active-high reset
//               i_locked     - PLL LOCKED (asynchronous)
//               i_sel_req    - requested CLKINSEL level (1 = CLKIN1)
//               i_pwrdwn_req - power-down request level
//               o_pll_rst    - PLL RST
//               o_pll_pwrdwn - PLL PWRDWN
//               o_clkinsel   - PLL CLKINSEL
//               o_ready      - PLL clocks usable (RUN)
//               o_fail       - sticky lock failure
//               o_retries    - timeouts in current attempt series
// Config      : PLL_RST_SEQ_AUTOSEL_EN - when defined, every lock timeout
//               that leads to a retry toggles o_clkinsel (input failover).
// Revision    : 1.0 - initial release
// ============================================================================
module pll_rst_seq
  import pll_rst_seq_pkg::*;
#(
  parameter int RST_CYCLES    = c_rst_cycles_dflt,
  parameter int LOCK_TIMEOUT  = c_lock_timeout_dflt,
  parameter int MAX_RETRY     = c_max_retry_dflt,
  parameter int SETTLE_CYCLES = c_settle_cycles_dflt
) (
  input  logic                 clk100,
  input  logic                 rst,
  input  logic                 i_locked,
  input  logic                 i_sel_req,
  input  logic                 i_pwrdwn_req,
  output logic                 o_pll_rst,
  output logic                 o_pll_pwrdwn,
  output logic                 o_clkinsel,
  output logic                 o_ready,
  output logic                 o_fail,
  output logic [c_retry_w-1:0] o_retries
);

  localparam int c_cnt_w = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES));

  localparam logic [c_cnt_w-1:0]   c_rst_last    = c_cnt_w'(RST_CYCLES - 1);
  localparam logic [c_cnt_w-1:0]   c_lock_last   = c_cnt_w'(LOCK_TIMEOUT - 1);
  localparam logic [c_cnt_w-1:0]   c_settle_last = c_cnt_w'(SETTLE_CYCLES - 1);
  localparam logic [c_retry_w-1:0] c_max_retry   = c_retry_w'(MAX_RETRY);

  logic                 w_locked_s;
  pll_state_e           r_state;
  pll_state_e           w_state_nxt;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_cnt_w-1:0]   w_cnt_nxt;
  logic [c_retry_w-1:0] r_retries;
  logic [c_retry_w-1:0] w_retries_nxt;
  // Low for exactly one cycle after rst release: the release edge only arms
  // the sequencer, so a release close to an edge never advances the FSM and
  // the first RESET pulse spans RST_CYCLES full cycles after edge 0.
  logic                 r_arm;
  logic                 w_sel_ref;
  logic                 w_load_sel;
  logic                 w_sel_nxt;
  logic                 w_pll_rst_nxt;
  logic                 w_pll_pwrdwn_nxt;
  logic                 w_ready_nxt;
  logic                 w_fail_nxt;

  pll_lock_sync #(
    .WIDTH (1)
  ) u_lock_sync (
    .clk (clk100),
    .rst (rst),
    .i_d (i_locked),
    .o_q (w_locked_s)
  );

  // --------------------------------------------------------------------------
  // State register (plus shared counter and retry count)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      r_arm     <= 1'b0;
      r_state   <= ST_RESET;
      r_cnt     <= '0;
      r_retries <= '0;
    end else begin
      r_arm     <= 1'b1;
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_retries <= w_retries_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_retries_nxt = r_retries;
    if (r_arm) begin
      if (i_pwrdwn_req && (r_state != ST_FAIL)) begin
        w_state_nxt = ST_PWRDN;
      end else begin
        case (r_state)
          ST_RESET: begin
            if (r_cnt == c_rst_last) w_state_nxt = ST_WAIT_LOCK;
          end
          ST_WAIT_LOCK: begin
            if (w_locked_s) begin
              w_state_nxt = ST_SETTLE;
            end else if (r_cnt == c_lock_last) begin
              if (r_retries == c_max_retry) begin
                w_state_nxt = ST_FAIL;
              end else begin
                w_state_nxt = ST_RESET;
                if (r_retries != '1) w_retries_nxt = r_retries + 1'b1;
              end
            end
          end
          ST_SETTLE: begin
            if (!w_locked_s) begin
              w_state_nxt = ST_RESET;
            end else if (r_cnt == c_settle_last) begin
              w_state_nxt   = ST_RUN;
              w_retries_nxt = '0;
            end
          end
          ST_RUN: begin
            if (!w_locked_s || (i_sel_req != w_sel_ref)) w_state_nxt = ST_RESET;
          end
          ST_PWRDN: begin
            // Request already known low here: leave and start a fresh series
            w_state_nxt   = ST_RESET;
            w_retries_nxt = '0;
          end
          ST_FAIL: begin
            w_state_nxt = ST_FAIL;
          end
          default: begin
            w_state_nxt = ST_RESET;
          end
        endcase
      end
    end
  end

  // Counter runs only in the timed states and restarts on any state change
  always_comb begin
    w_cnt_nxt = '0;
    if (r_arm && (w_state_nxt == r_state) &&
        (r_state inside {ST_RESET, ST_WAIT_LOCK, ST_SETTLE})) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Output decode of the next state (registered below)
  // --------------------------------------------------------------------------
  always_comb begin
    w_pll_rst_nxt    = w_state_nxt inside {ST_RESET, ST_PWRDN, ST_FAIL};
    w_pll_pwrdwn_nxt = (w_state_nxt == ST_PWRDN);
    w_ready_nxt      = (w_state_nxt == ST_RUN);
    w_fail_nxt       = (w_state_nxt == ST_FAIL);
  end

  // CLKINSEL only moves while PLL RST is being asserted: on RESET entry and on
  // the arming edge that follows rst release.
  assign w_load_sel = !r_arm || ((w_state_nxt == ST_RESET) && (r_state != ST_RESET));

`ifdef PLL_RST_SEQ_AUTOSEL_EN
  // WAIT_LOCK -> RESET only happens on a retrying timeout
  logic w_timeout_retry;
  logic r_sel_ref;

  assign w_timeout_retry = (r_state == ST_WAIT_LOCK) && (w_state_nxt == ST_RESET);
  assign w_sel_nxt       = w_timeout_retry ? ~o_clkinsel : i_sel_req;

  // Failover may leave o_clkinsel != i_sel_req, so the RUN switch rule tracks
  // the last sampled request rather than the pin.
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      r_sel_ref <= 1'b1;
    end else if (w_load_sel) begin
      r_sel_ref <= i_sel_req;
    end
  end
  assign w_sel_ref = r_sel_ref;
`else
  assign w_sel_nxt = i_sel_req;
  assign w_sel_ref = o_clkinsel;
`endif

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      o_pll_rst    <= 1'b1;
      o_pll_pwrdwn <= 1'b0;
      o_clkinsel   <= 1'b1;
      o_ready      <= 1'b0;
      o_fail       <= 1'b0;
    end else begin
      o_pll_rst    <= w_pll_rst_nxt;
      o_pll_pwrdwn <= w_pll_pwrdwn_nxt;
      o_ready      <= w_ready_nxt;
      o_fail       <= w_fail_nxt;
      if (w_load_sel) o_clkinsel <= w_sel_nxt;
    end
  end

  assign o_retries = r_retries;

endmodule
`default_nettype wire

// File: tb/tb_pll_rst_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_rst_seq
// Description : Self-checking bench for pll_rst_seq. Edge n is the n-th
//               clk100 rising edge after rst release (first edge = 0);
//               outputs are sampled 1 time unit after an edge and inputs are
//               driven right after sampling. Observed bus:
//               {o_pll_rst, o_pll_pwrdwn, o_clkinsel, o_ready, o_fail,
//                o_retries[1:0]}
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_rst_seq;

  logic       clk100 = 1'b0;
  logic       rst = 1'b1;
  logic       i_locked = 1'b0;
  logic       i_sel_req = 1'b1;
  logic       i_pwrdwn_req = 1'b0;
  logic       o_pll_rst;
  logic       o_pll_pwrdwn;
  logic       o_clkinsel;
  logic       o_ready;
  logic       o_fail;
  logic [1:0] o_retries;
  logic [6:0] w_obs;

`ifdef PLL_RST_SEQ_AUTOSEL_EN
  localparam logic c_autosel = 1'b1;
`else
  localparam logic c_autosel = 1'b0;
`endif
  // Expected CLKINSEL after an odd number of retrying timeouts (sel_req = 1)
  localparam logic c_sel_odd = c_autosel ? 1'b0 : 1'b1;

  int checks = 0;
  int errors = 0;
  int edge_n = -1;

  typedef struct {
    int         e;
    logic       l;
    logic       s;
    logic       p;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[21];

  pll_rst_seq #(
    .RST_CYCLES    (16),
    .LOCK_TIMEOUT  (256),
    .MAX_RETRY     (3),
    .SETTLE_CYCLES (8)
  ) dut (
    .clk100       (clk100),
    .rst          (rst),
    .i_locked     (i_locked),
    .i_sel_req    (i_sel_req),
    .i_pwrdwn_req (i_pwrdwn_req),
    .o_pll_rst    (o_pll_rst),
    .o_pll_pwrdwn (o_pll_pwrdwn),
    .o_clkinsel   (o_clkinsel),
    .o_ready      (o_ready),
    .o_fail       (o_fail),
    .o_retries    (o_retries)
  );

  assign w_obs = {o_pll_rst, o_pll_pwrdwn, o_clkinsel, o_ready, o_fail, o_retries};

  always #5 clk100 = ~clk100;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", edge_n);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk100);
    edge_n++;
    #1;
  endtask

  task automatic goto_edge(input int e);
    while (edge_n < e) tick();
  endtask

  task automatic chk(input string name, input logic [6:0] exp);
    checks++;
    if (w_obs !== exp) begin
      errors++;
      $display("FAIL %s @edge %0d: got %b expected %b (rst,pd,sel,rdy,fail,ret)",
               name, edge_n, w_obs, exp);
    end
  endtask

  task automatic drive(input logic l, input logic s, input logic p);
    i_locked     = l;
    i_sel_req    = s;
    i_pwrdwn_req = p;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0);
    repeat (3) @(posedge clk100);
    @(negedge clk100);
    rst    = 1'b0;
    edge_n = -1;
  endtask

  initial begin
    // Nominal lock at 40, lock loss at 100 for 20 cycles, input switch at 150
    vecs = '{
      '{0,   1'b0, 1'b1, 1'b0, 7'b1010000},
      '{15,  1'b0, 1'b1, 1'b0, 7'b1010000},
      '{16,  1'b0, 1'b1, 1'b0, 7'b0010000},
      '{40,  1'b1, 1'b1, 1'b0, 7'b0010000},
      '{43,  1'b1, 1'b1, 1'b0, 7'b0010000},
      '{50,  1'b1, 1'b1, 1'b0, 7'b0010000},
      '{51,  1'b1, 1'b1, 1'b0, 7'b0011000},
      '{100, 1'b0, 1'b1, 1'b0, 7'b0011000},
      '{102, 1'b0, 1'b1, 1'b0, 7'b0011000},
      '{103, 1'b0, 1'b1, 1'b0, 7'b1010000},
      '{118, 1'b0, 1'b1, 1'b0, 7'b1010000},
      '{119, 1'b0, 1'b1, 1'b0, 7'b0010000},
      '{120, 1'b1, 1'b1, 1'b0, 7'b0010000},
      '{130, 1'b1, 1'b1, 1'b0, 7'b0010000},
      '{131, 1'b1, 1'b1, 1'b0, 7'b0011000},
      '{150, 1'b1, 1'b0, 1'b0, 7'b0011000},
      '{151, 1'b1, 1'b0, 1'b0, 7'b1000000},
      '{166, 1'b1, 1'b0, 1'b0, 7'b1000000},
      '{167, 1'b1, 1'b0, 1'b0, 7'b0000000},
      '{175, 1'b1, 1'b0, 1'b0, 7'b0000000},
      '{176, 1'b1, 1'b0, 1'b0, 7'b0001000}
    };

    do_reset();
    for (int i = 0; i < 21; i++) begin
      goto_edge(vecs[i].e);
      chk($sformatf("vec%0d", i), vecs[i].exp);
      drive(vecs[i].l, vecs[i].s, vecs[i].p);
    end

    // Asynchronous reset in RUN on CLKIN2: everything back without a clock
    goto_edge(180);
    rst = 1'b1;
    #1;
    chk("async_reset", 7'b1010000);

    // Never locks: three retries, then sticky FAIL
    do_reset();
    goto_edge(271);  chk("nolock_wait0",  {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0});
    goto_edge(272);  chk("nolock_retry1", {1'b1, 1'b0, c_sel_odd, 1'b0, 1'b0, 2'd1});
    goto_edge(544);  chk("nolock_retry2", {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2});
    goto_edge(816);  chk("nolock_retry3", {1'b1, 1'b0, c_sel_odd, 1'b0, 1'b0, 2'd3});
    goto_edge(1087); chk("nolock_prefail", {1'b0, 1'b0, c_sel_odd, 1'b0, 1'b0, 2'd3});
    goto_edge(1088); chk("nolock_fail",   {1'b1, 1'b0, c_sel_odd, 1'b0, 1'b1, 2'd3});
    goto_edge(1090); drive(1'b1, 1'b1, 1'b0);
    goto_edge(1100); chk("fail_late_lock", {1'b1, 1'b0, c_sel_odd, 1'b0, 1'b1, 2'd3});
    drive(1'b1, 1'b1, 1'b1);
    goto_edge(1101); chk("fail_pwrdwn_ign", {1'b1, 1'b0, c_sel_odd, 1'b0, 1'b1, 2'd3});
    goto_edge(1110); chk("fail_sticky",   {1'b1, 1'b0, c_sel_odd, 1'b0, 1'b1, 2'd3});

    // Power-down during WAIT_LOCK after one timeout
    do_reset();
    goto_edge(272); chk("pd_retry1",   {1'b1, 1'b0, c_sel_odd, 1'b0, 1'b0, 2'd1});
    goto_edge(300); chk("pd_wait",     {1'b0, 1'b0, c_sel_odd, 1'b0, 1'b0, 2'd1});
    drive(1'b0, 1'b1, 1'b1);
    goto_edge(301); chk("pd_enter",    {1'b1, 1'b1, c_sel_odd, 1'b0, 1'b0, 2'd1});
    goto_edge(310); chk("pd_hold",     {1'b1, 1'b1, c_sel_odd, 1'b0, 1'b0, 2'd1});
    drive(1'b0, 1'b1, 1'b0);
    goto_edge(311); chk("pd_release",  7'b1010000);
    goto_edge(326); chk("pd_rst_hold", 7'b1010000);
    goto_edge(327); chk("pd_rst_done", 7'b0010000);

`ifdef PLL_RST_SEQ_AUTOSEL_EN
    // Failover: first timeout moves to CLKIN2, which then locks and runs
    do_reset();
    goto_edge(272); chk("as_toggle", 7'b1000001);
    goto_edge(280); drive(1'b1, 1'b1, 1'b0);
    goto_edge(288); chk("as_wait",   7'b0000001);
    goto_edge(296); chk("as_settle", 7'b0000001);
    goto_edge(297); chk("as_run",    7'b0001000);
    goto_edge(310); chk("as_stay",   7'b0001000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
